branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch comparator.
- Adds XLEN generality, a registered one-cycle resolve stage, and a direct-mapped branch history table (BHT) of saturating counters.
- Provides fetch-side prediction and execute-side resolution with misprediction detection.
- Sits between IF (prediction lookup) and EX (resolution) of the pipeline.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 64, counter table depth; power of two, minimum 2.
- CTR_W, 2, saturating counter width; minimum 1.
- IDX_W, log2(BHT_ENTRIES), derived localparam, not overridable.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_n_in  in  1  reset, asynchronous, active-low.
- pred_valid_in  in  1  lookup request from IF.
- pred_pc_in  in  XLEN  PC of the fetched instruction.
- pred_valid_out  out  1  registered; lookup result valid.
- pred_taken_out  out  1  registered; predicted direction.
- res_valid_in  in  1  resolve request from EX.
- res_pc_in  in  XLEN  PC of the resolving instruction.
- opcode_6_2_in  in  5  instr[6:2].
- funct3_in  in  3  instr[14:12].
- rs1_in  in  XLEN  operand 1.
- rs2_in  in  XLEN  operand 2.
- res_pred_taken_in  in  1  prediction carried down the pipe for this instruction.
- flush_in  in  1  synchronous kill of the registered outputs.
- res_valid_out  out  1  registered; resolve result valid.
- branch_taken_out  out  1  registered; actual direction.
- mispredict_out  out  1  registered; actual direction differs from res_pred_taken_in.
- illegal_out  out  1  registered; branch opcode with funct3 010 or 011.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All outputs 0.
  - Every BHT counter set to 2^(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2).
- Index: pc[IDX_W+1:2]; pc[1:0] ignored.
- Lookup (latency 1):
  - pred_valid_out <= pred_valid_in & ~flush_in.
  - pred_taken_out <= MSB of counter[idx(pred_pc_in)] when pred_valid_in, else 0.
- Resolve decode (combinational), registered with latency 1:
  - 11011 (JAL) and 11001 (JALR): taken = 1; no BHT update.
  - 11000 (BRANCH):
    - funct3 000 eq; 001 ne.
    - funct3 100 signed lt; 101 signed ge.
    - funct3 110 unsigned lt; 111 unsigned ge.
    - funct3 010/011: taken = 0, illegal = 1, no BHT update.
  - Any other opcode: taken = 0; res_valid_out still follows res_valid_in; no update.
- Resolve outputs:
  - res_valid_out <= res_valid_in & ~flush_in.
  - branch_taken_out, mispredict_out and illegal_out are forced to 0 whenever the registered res_valid_out is 0.
  - mispredict = res_valid & (taken != res_pred_taken_in). For JAL/JALR this flags a not-taken prediction.
- BHT update (legal conditional branch only, on the same edge the outputs register):
  - Taken: counter increments, saturating at 2^CTR_W-1.
  - Not taken: counter decrements, saturating at 0.
- flush_in suppresses only the registered outputs. A resolve presented together with flush still updates the BHT, because EX-stage resolution is architecturally committed.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update counter (read-before-write).
- Lookup and resolve are independent and may occur in the same cycle.
- Reset mid-operation: all state returns immediately to reset values; in-flight results are lost.

Decomposition:
- Shared package: opcode constants (OP_BRANCH=11000, OP_JAL=11011, OP_JALR=11001) and funct3 encodings (BEQ, BNE, BLT, BGE, BLTU, BGEU).
- One sub-module: bht_counter_table, holding the counter array with its read port, update port and saturation logic.
- Comparator/decode stays in the top level.

Test Plan:
- Reset → lookup pc 0x0000_0040 → pred_valid_out=1, pred_taken_out=0 next cycle.
- Resolve BEQ at pc 0x40, rs1=rs2=0x5, pred=0 → taken=1, mispredict=1. Repeat the resolve → subsequent lookup of 0x40 returns taken=1 (counter 01→10→11). Two not-taken resolves then give 01, predicted not taken.
- Signed vs unsigned: rs1=0xFFFF_FFFF, rs2=0x1:
  - BLT → not taken... correction: BLT (signed, -1 < 1) → taken.
  - BLTU → not taken.
  - BGE → not taken.
  - BGEU → taken.
- JAL with pred=0 → taken=1, mispredict=1, no BHT change. funct3=010 on BRANCH → illegal=1, taken=0, counter unchanged.
- Same-cycle lookup and update of idx 5 (pc 0x14), counter at 01, taken update → lookup returns 0; the following lookup returns 1.
- flush_in with a resolve → res_valid_out=0 and mispredict=0, but the counter still updates. rst_n_in pulsed mid-stream → all outputs 0 asynchronously and counters return to 01.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared decode constants for the branch prediction / resolution unit.
// Holds the RV32 opcode[6:2] values that the resolve stage recognises and
// the conditional-branch funct3 encodings.
package branch_predict_unit_pkg;

    // instr[6:2] values
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    // funct3 encodings for conditional branches (010/011 are reserved)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_predict_unit_bht_counter_table.sv
// Direct-mapped table of saturating direction counters.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rd_idx          lookup index
//   rd_msb          MSB of the addressed counter (combinational, pre-update value)
//   upd_en          apply an update this cycle
//   upd_idx         index of the counter to update
//   upd_taken       1: increment (saturate at max), 0: decrement (saturate at 0)
// Every counter resets to the weakly-not-taken value 2^(CTR_W-1)-1. The table
// needs a per-entry reset, so it is built from flops rather than a RAM.
module bht_counter_table #(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_msb,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);
    import branch_predict_unit_pkg::*;

    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN = '0;

    logic [CTR_W-1:0] ctr_reg [ENTRIES];
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_next;

    // Read port sees the current (pre-edge) value, which gives
    // read-before-write when lookup and update hit the same entry.
    assign rd_msb  = ctr_reg[rd_idx][CTR_W-1];
    assign ctr_cur = ctr_reg[upd_idx];

    always_comb begin
        ctr_next = ctr_cur;
        if (upd_taken) begin
            if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_W'(1);
        end else begin
            if (ctr_cur != CTR_MIN) ctr_next = ctr_cur - CTR_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctr_reg[gi] <= CTR_RST;
                end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
                    ctr_reg[gi] <= ctr_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit between IF and EX.
// Ports:
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   pred_valid_in, pred_pc_in   IF lookup request
//   pred_valid_out, pred_taken_out  registered lookup result (latency 1)
//   res_valid_in, res_pc_in     EX resolve request
//   opcode_6_2_in, funct3_in    instruction fields instr[6:2], instr[14:12]
//   rs1_in, rs2_in              comparison operands
//   res_pred_taken_in           prediction carried down the pipe
//   flush_in                    kills the registered outputs for this edge
//   res_valid_out, branch_taken_out, mispredict_out, illegal_out
//                               registered resolve result (latency 1)
// Counters are indexed by pc[IDX_W+1:2]. Only legal conditional branches
// train the table, and they do so even under flush because resolution in EX
// is committed.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_W       = 2
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            pred_valid_in,
    input  logic [XLEN-1:0] pred_pc_in,
    output logic            pred_valid_out,
    output logic            pred_taken_out,
    input  logic            res_valid_in,
    input  logic [XLEN-1:0] res_pc_in,
    input  logic [4:0]      opcode_6_2_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic            res_pred_taken_in,
    input  logic            flush_in,
    output logic            res_valid_out,
    output logic            branch_taken_out,
    output logic            mispredict_out,
    output logic            illegal_out
);
    import branch_predict_unit_pkg::*;

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             pred_msb;
    logic             taken;
    logic             illegal;
    logic             cond_branch;
    logic             upd_en;
    logic             res_keep;
    logic             pred_keep;

    assign pred_idx = pred_pc_in[IDX_W+1:2];
    assign res_idx  = res_pc_in[IDX_W+1:2];

    // PC bits outside the index do not participate in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_in[1:0], res_pc_in[1:0],
                              pred_pc_in[XLEN-1:IDX_W+2], res_pc_in[XLEN-1:IDX_W+2]};

    // Resolve decode and comparison
    always_comb begin
        taken       = 1'b0;
        illegal     = 1'b0;
        cond_branch = 1'b0;
        case (opcode_6_2_in)
            OP_JAL, OP_JALR: taken = 1'b1;
            OP_BRANCH: begin
                cond_branch = 1'b1;
                case (funct3_in)
                    F3_BEQ:  taken = (rs1_in == rs2_in);
                    F3_BNE:  taken = (rs1_in != rs2_in);
                    F3_BLT:  taken = ($signed(rs1_in) <  $signed(rs2_in));
                    F3_BGE:  taken = ($signed(rs1_in) >= $signed(rs2_in));
                    F3_BLTU: taken = (rs1_in <  rs2_in);
                    F3_BGEU: taken = (rs1_in >= rs2_in);
                    default: begin
                        illegal     = 1'b1;
                        cond_branch = 1'b0;
                    end
                endcase
            end
            default: ;
        endcase
    end

    assign upd_en    = res_valid_in & cond_branch;
    assign res_keep  = res_valid_in & ~flush_in;
    assign pred_keep = pred_valid_in & ~flush_in;

    bht_counter_table #(
        .ENTRIES (BHT_ENTRIES),
        .CTR_W   (CTR_W),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .rd_idx    (pred_idx),
        .rd_msb    (pred_msb),
        .upd_en    (upd_en),
        .upd_idx   (res_idx),
        .upd_taken (taken)
    );

    // Result qualifiers are gated by the same valid that feeds res_valid_out,
    // so they can never be nonzero while res_valid_out is low.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pred_valid_out   <= 1'b0;
            pred_taken_out   <= 1'b0;
            res_valid_out    <= 1'b0;
            branch_taken_out <= 1'b0;
            mispredict_out   <= 1'b0;
            illegal_out      <= 1'b0;
        end else begin
            pred_valid_out   <= pred_keep;
            pred_taken_out   <= pred_keep & pred_msb;
            res_valid_out    <= res_keep;
            branch_taken_out <= res_keep & taken;
            mispredict_out   <= res_keep & (taken != res_pred_taken_in);
            illegal_out      <= res_keep & illegal;
        end
    end

endmodule
